spike_generator_array: RTL and testbench

SPIKE_GENERATOR_ARRAY -- requirements
Module: spike_generator_array

---
 rtl/spike_generator_array_pkg.sv | 15 +
 rtl/spike_generator_array_if.sv | 33 +++
 rtl/spike_gen_mem.sv | 50 +++++
 rtl/spike_generator_array.sv | 154 +++++++++++++++
 tb/tb_spike_generator_array.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spike_generator_array_pkg.sv
// Shared defaults and FSM state encoding for the spike generator array.
package spike_generator_array_pkg;

  localparam int NGENS_DEF   = 8;
  localparam int NPERIOD_DEF = 16;
  localparam int NTAG_DEF    = 11;
  localparam int NCT_DEF     = 10;
  localparam int NUM_GENS_DEF = 1 << NGENS_DEF;

  // Sweep FSM state encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_EMIT = 2'd2;

endpackage

// File: rtl/spike_generator_array_if.sv
// Channels of the spike generator array: programming input and tag/count output.
interface spike_prog_if
  import spike_generator_array_pkg::*;
#(
  parameter int Ngens   = NGENS_DEF,
  parameter int Nperiod = NPERIOD_DEF,
  parameter int Ntag    = NTAG_DEF
) ();
  logic [Ngens-1:0]   gen_idx;
  logic [Nperiod-1:0] period;
  logic [Nperiod-1:0] ticks;
  logic [Ntag-1:0]    tag;
  logic               v;
  logic               a;

  modport master (output gen_idx, period, ticks, tag, v, input a);
  modport slave  (input gen_idx, period, ticks, tag, v, output a);
endinterface

interface tag_ct_if
  import spike_generator_array_pkg::*;
#(
  parameter int Ntag = NTAG_DEF,
  parameter int Nct  = NCT_DEF
) ();
  logic [Ntag-1:0] tag;
  logic [Nct-1:0]  ct;
  logic            v;
  logic            r;

  modport master (output tag, ct, v, input r);
  modport slave  (input tag, ct, v, output r);
endinterface

// File: rtl/spike_gen_mem.sv
// Per-generator state store (period, ticks, tag): one write port, one read port.
module spike_gen_mem
  import spike_generator_array_pkg::*;
#(
  parameter int Ngens   = NGENS_DEF,
  parameter int Nperiod = NPERIOD_DEF,
  parameter int Ntag    = NTAG_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [Ngens-1:0]   waddr,
  input  logic [Nperiod-1:0] w_period,
  input  logic [Nperiod-1:0] w_ticks,
  input  logic [Ntag-1:0]    w_tag,
  input  logic [Ngens-1:0]   raddr,
  output logic [Nperiod-1:0] rd_period,
  output logic [Nperiod-1:0] rd_ticks,
  output logic [Ntag-1:0]    rd_tag
);

  localparam int Depth = 1 << Ngens;

  logic [Nperiod-1:0] period_q [Depth];
  logic [Nperiod-1:0] ticks_q  [Depth];
  logic [Ntag-1:0]    tag_q    [Depth];

  // Entry update: programming write or sweep tick update, already arbitrated upstream.
  // NOTE: this is a flop array, not a RAM macro, and period==0 is what marks a
  // generator disabled, so every entry must be cleared by reset. Sequential
  // state uses <= so all entries update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < Depth; i++) begin
        period_q[i] <= '0;
        ticks_q[i]  <= '0;
        tag_q[i]    <= '0;
      end
    end else if (we) begin
      period_q[waddr] <= w_period;
      ticks_q[waddr]  <= w_ticks;
      tag_q[waddr]    <= w_tag;
    end
  end

  assign rd_period = period_q[raddr];
  assign rd_ticks  = ticks_q[raddr];
  assign rd_tag    = tag_q[raddr];

endmodule

// File: rtl/spike_generator_array.sv
// Array of programmable periodic spike generators swept once per time unit.
module spike_generator_array
  import spike_generator_array_pkg::*;
#(
  parameter int Ngens   = NGENS_DEF,
  parameter int Nperiod = NPERIOD_DEF,
  parameter int Ntag    = NTAG_DEF,
  parameter int Nct     = NCT_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         time_unit_pulse,
  spike_prog_if.slave  prog,
  tag_ct_if.master     out,
  output logic         overrun
);

  logic [1:0]         state;
  // One spare bit so the pointer can never alias back to 0 mid-sweep.
  logic [Ngens:0]     ptr;
  logic [Ngens-1:0]   cur_idx;
  logic               is_last;
  logic               pending;
  logic               sweep_start;
  logic               prog_fire;
  logic               gen_active;
  logic               gen_fire;

  logic               out_v;
  logic [Ntag-1:0]    out_tag;
  logic [Nct-1:0]     out_ct;

  logic               mem_we;
  logic [Ngens-1:0]   mem_waddr;
  logic [Nperiod-1:0] mem_w_period;
  logic [Nperiod-1:0] mem_w_ticks;
  logic [Ntag-1:0]    mem_w_tag;
  logic [Nperiod-1:0] rd_period;
  logic [Nperiod-1:0] rd_ticks;
  logic [Ntag-1:0]    rd_tag;

  assign cur_idx     = ptr[Ngens-1:0];
  assign is_last     = &cur_idx;
  assign sweep_start = (state == ST_IDLE) && pending;
  assign prog.a      = (state == ST_IDLE);
  assign prog_fire   = prog.v && prog.a;
  assign gen_active  = (rd_period != '0);
  assign gen_fire    = (state == ST_SCAN) && gen_active && (rd_ticks == '0);

  assign out.v   = out_v;
  assign out.tag = out_tag;
  assign out.ct  = out_ct;

  spike_gen_mem #(
    .Ngens   (Ngens),
    .Nperiod (Nperiod),
    .Ntag    (Ntag)
  ) u_mem (
    .clk       (clk),
    .reset     (reset),
    .we        (mem_we),
    .waddr     (mem_waddr),
    .w_period  (mem_w_period),
    .w_ticks   (mem_w_ticks),
    .w_tag     (mem_w_tag),
    .raddr     (cur_idx),
    .rd_period (rd_period),
    .rd_ticks  (rd_ticks),
    .rd_tag    (rd_tag)
  );

  // Write-port arbitration: a programming write (IDLE only) or the sweep's tick update.
  // NOTE: every output gets a default before any branch so no latch is inferred.
  always_comb begin
    mem_we       = 1'b0;
    mem_waddr    = cur_idx;
    mem_w_period = rd_period;
    mem_w_ticks  = rd_ticks;
    mem_w_tag    = rd_tag;
    if (prog_fire) begin
      mem_we       = 1'b1;
      mem_waddr    = prog.gen_idx;
      mem_w_period = prog.period;
      mem_w_ticks  = prog.ticks;
      mem_w_tag    = prog.tag;
    end else if ((state == ST_SCAN) && gen_active) begin
      mem_we      = 1'b1;
      mem_w_ticks = (rd_ticks == '0) ? rd_period - Nperiod'(1) : rd_ticks - Nperiod'(1);
    end
  end

  // At most one queued time unit; a pulse arriving on top of a queued one is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
      overrun <= 1'b0;
    end else if (time_unit_pulse) begin
      if (pending && !sweep_start) overrun <= 1'b1;
      pending <= 1'b1;
    end else if (sweep_start) begin
      pending <= 1'b0;
    end
  end

  // Sweep FSM: walk every generator once, pausing in EMIT until a spike is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      out_v   <= 1'b0;
      out_tag <= '0;
      out_ct  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pending) begin
            state <= ST_SCAN;
            ptr   <= '0;
          end
        end
        ST_SCAN: begin
          if (gen_fire) begin
            out_v   <= 1'b1;
            out_tag <= rd_tag;
            out_ct  <= Nct'(1);
            state   <= ST_EMIT;
          end else if (is_last) begin
            state <= ST_IDLE;
            ptr   <= '0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        ST_EMIT: begin
          if (out.r) begin
            out_v <= 1'b0;
            if (is_last) begin
              state <= ST_IDLE;
              ptr   <= '0;
            end else begin
              state <= ST_SCAN;
              ptr   <= ptr + 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          ptr   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spike_generator_array.sv
// Self-checking bench for spike_generator_array with a per-time-unit spike model.
module tb_spike_generator_array;
  import spike_generator_array_pkg::*;

  localparam int NG = 8;
  localparam int NP = 16;
  localparam int NT = 11;
  localparam int NC = 10;
  localparam int NUM = 1 << NG;

  typedef struct packed {
    logic [NT-1:0] tag;
    logic [NC-1:0] ct;
  } spike_t;

  logic clk = 1'b0;
  logic reset;
  logic time_unit_pulse;
  logic overrun;

  spike_prog_if #(.Ngens(NG), .Nperiod(NP), .Ntag(NT)) prog_bus ();
  tag_ct_if #(.Ntag(NT), .Nct(NC)) out_bus ();

  spike_generator_array #(
    .Ngens(NG), .Nperiod(NP), .Ntag(NT), .Nct(NC)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .time_unit_pulse (time_unit_pulse),
    .prog            (prog_bus),
    .out             (out_bus),
    .overrun         (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference model: a generator programmed before unit (base+1) spikes on
  // relative unit r when r >= ticks+1 and (r - ticks - 1) is a multiple of period.
  int m_period [NUM];
  int m_ticks  [NUM];
  int m_base   [NUM];
  logic [NT-1:0] m_tag [NUM];
  int units = 0;
  logic [NT-1:0] exp_q [$];

  spike_t obs_q [$];
  int v_seen = 0;

  // Monitor: log accepted spikes and count any cycle with out.v high.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_bus.v === 1'b1) v_seen++;
      if (out_bus.v === 1'b1 && out_bus.r === 1'b1)
        obs_q.push_back('{tag: out_bus.tag, ct: out_bus.ct});
    end
  end

  task automatic model_clear();
    for (int g = 0; g < NUM; g++) begin
      m_period[g] = 0; m_ticks[g] = 0; m_base[g] = 0; m_tag[g] = '0;
    end
    units = 0;
  endtask

  // Advance the model by one unit and append its spikes, in index order, to exp_q.
  task automatic model_next_unit();
    int r;
    units++;
    for (int g = 0; g < NUM; g++) begin
      if (m_period[g] != 0) begin
        r = units - m_base[g];
        if (r >= m_ticks[g] + 1 && ((r - m_ticks[g] - 1) % m_period[g]) == 0)
          exp_q.push_back(m_tag[g]);
      end
    end
  endtask

  task automatic pulse();
    @(posedge clk); #1 time_unit_pulse = 1'b1;
    @(posedge clk); #1 time_unit_pulse = 1'b0;
  endtask

  // Programming write; also checks that prog.a follows prog.v while idle.
  task automatic program_gen(input int idx, input int per, input int tk, input logic [NT-1:0] tg,
                             input bit with_pulse);
    @(posedge clk); #1;
    prog_bus.gen_idx = NG'(idx);
    prog_bus.period  = NP'(per);
    prog_bus.ticks   = NP'(tk);
    prog_bus.tag     = tg;
    prog_bus.v       = 1'b1;
    time_unit_pulse  = with_pulse;
    @(negedge clk);
    checks++;
    if (prog_bus.a !== 1'b1) $display("FAIL prog_a gen %0d: got %b expected 1", idx, prog_bus.a);
    else passed++;
    @(posedge clk); #1;
    prog_bus.v      = 1'b0;
    time_unit_pulse = 1'b0;
    m_period[idx] = per; m_ticks[idx] = tk; m_tag[idx] = tg; m_base[idx] = units;
  endtask

  task automatic wait_for_v(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (out_bus.v === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    checks++;
    if (out_bus.v !== 1'b0 || out_bus.tag !== '0 || out_bus.ct !== '0)
      $display("FAIL reset_out: got v=%b tag=%h ct=%h expected 0/0/0", out_bus.v, out_bus.tag, out_bus.ct);
    else passed++;
    checks++;
    if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b expected 0", overrun);
    else passed++;
    program_gen(0, 0, 0, '0, 1'b0);
  endtask

  task automatic test_idle_pulses();
    v_seen = 0;
    for (int u = 0; u < 10; u++) begin
      pulse();
      model_next_unit();
      repeat (300) @(posedge clk);
    end
    checks++;
    if (v_seen != 0 || exp_q.size() != 0)
      $display("FAIL idle_no_spikes: got %0d out.v cycles expected 0 (model %0d)", v_seen, exp_q.size());
    else passed++;
    checks++;
    if (overrun !== 1'b0) $display("FAIL idle_overrun: got %b expected 0", overrun);
    else passed++;
  endtask

  task automatic test_gen5();
    program_gen(5, 3, 0, 11'h02A, 1'b0);
    for (int u = 1; u <= 7; u++) begin
      exp_q.delete(); obs_q.delete();
      pulse();
      model_next_unit();
      repeat (300) @(posedge clk);
      checks++;
      if (obs_q.size() != exp_q.size())
        $display("FAIL gen5 unit %0d count: got %0d expected %0d", u, obs_q.size(), exp_q.size());
      else passed++;
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i].tag !== exp_q[i] || obs_q[i].ct !== NC'(1))
          $display("FAIL gen5 unit %0d spike: got tag=%h ct=%0d expected tag=%h ct=1",
                   u, obs_q[i].tag, obs_q[i].ct, exp_q[i]);
        else passed++;
      end
    end
    program_gen(5, 0, 0, '0, 1'b0);
  endtask

  task automatic test_same_cycle();
    exp_q.delete(); obs_q.delete();
    program_gen(3, 2, 1, 11'h033, 1'b1);
    model_next_unit();
    repeat (300) @(posedge clk);
    for (int u = 2; u <= 4; u++) begin
      pulse();
      model_next_unit();
      repeat (300) @(posedge clk);
    end
    checks++;
    if (obs_q.size() != exp_q.size() || exp_q.size() != 2)
      $display("FAIL same_cycle count: got %0d expected %0d", obs_q.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].tag !== exp_q[i] || obs_q[i].ct !== NC'(1))
        $display("FAIL same_cycle spike %0d: got tag=%h ct=%0d expected tag=%h ct=1",
                 i, obs_q[i].tag, obs_q[i].ct, exp_q[i]);
      else passed++;
    end
    program_gen(3, 0, 0, '0, 1'b0);
  endtask

  task automatic test_stall();
    bit ok;
    bit stable;
    logic [NT-1:0] held;
    program_gen(0, 1, 0, 11'h011, 1'b0);
    program_gen(255, 1, 0, 11'h7F5, 1'b0);
    exp_q.delete(); obs_q.delete();
    out_bus.r = 1'b0;
    pulse();
    model_next_unit();
    wait_for_v(ok);
    checks++;
    if (!ok) $display("FAIL stall_wait_v: got timeout expected out.v");
    else passed++;
    held = out_bus.tag;
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (out_bus.v !== 1'b1 || out_bus.tag !== held || out_bus.ct !== NC'(1)) stable = 1'b0;
    end
    checks++;
    if (!stable || held !== 11'h011)
      $display("FAIL stall_hold: got stable=%b tag=%h expected stable=1 tag=011", stable, held);
    else passed++;
    @(posedge clk); #1 out_bus.r = 1'b1;
    repeat (300) @(posedge clk);
    pulse();
    model_next_unit();
    repeat (300) @(posedge clk);
    checks++;
    if (obs_q.size() != exp_q.size() || exp_q.size() != 4)
      $display("FAIL stall_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].tag !== exp_q[i])
        $display("FAIL stall_order %0d: got tag=%h expected %h", i, obs_q[i].tag, exp_q[i]);
      else passed++;
    end
  endtask

  task automatic test_overrun();
    int n_after;
    exp_q.delete(); obs_q.delete();
    out_bus.r = 1'b0;
    pulse();
    repeat (10) @(posedge clk);
    pulse();
    repeat (5) @(posedge clk);
    pulse();
    @(negedge clk);
    checks++;
    if (overrun !== 1'b1) $display("FAIL overrun_set: got %b expected 1", overrun);
    else passed++;
    model_next_unit();
    model_next_unit();
    @(posedge clk); #1 out_bus.r = 1'b1;
    repeat (700) @(posedge clk);
    n_after = obs_q.size();
    checks++;
    if (obs_q.size() != exp_q.size())
      $display("FAIL overrun_sweeps: got %0d spikes expected %0d", obs_q.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].tag !== exp_q[i])
        $display("FAIL overrun_order %0d: got tag=%h expected %h", i, obs_q[i].tag, exp_q[i]);
      else passed++;
    end
    repeat (400) @(posedge clk);
    checks++;
    if (obs_q.size() != n_after || overrun !== 1'b1)
      $display("FAIL overrun_no_extra: got %0d spikes overrun=%b expected %0d overrun=1",
               obs_q.size(), overrun, n_after);
    else passed++;
  endtask

  task automatic test_reset_mid_emit();
    bit ok;
    out_bus.r = 1'b0;
    pulse();
    wait_for_v(ok);
    checks++;
    if (!ok) $display("FAIL rst_wait_v: got timeout expected out.v");
    else passed++;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (out_bus.v !== 1'b0 || out_bus.tag !== '0 || overrun !== 1'b0)
      $display("FAIL rst_async: got v=%b tag=%h overrun=%b expected 0/0/0", out_bus.v, out_bus.tag, overrun);
    else passed++;
    @(posedge clk); #1 reset = 1'b0;
    out_bus.r = 1'b1;
    model_clear();
    exp_q.delete();
    program_gen(0, 0, 0, '0, 1'b0);
    v_seen = 0;
    for (int u = 0; u < 3; u++) begin
      pulse();
      model_next_unit();
      repeat (300) @(posedge clk);
    end
    checks++;
    if (v_seen != 0 || exp_q.size() != 0)
      $display("FAIL rst_disabled: got %0d out.v cycles expected 0", v_seen);
    else passed++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++)
      program_gen(k * 60 + int'($urandom_range(0, 59)), int'($urandom_range(1, 4)),
                  int'($urandom_range(0, 3)), {2'(k), 9'($urandom)}, 1'b0);
    for (int u = 0; u < 12; u++) begin
      exp_q.delete(); obs_q.delete();
      pulse();
      model_next_unit();
      repeat (300) @(posedge clk);
      checks++;
      if (obs_q.size() != exp_q.size())
        $display("FAIL random unit %0d count: got %0d expected %0d", units, obs_q.size(), exp_q.size());
      else passed++;
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i].tag !== exp_q[i] || obs_q[i].ct !== NC'(1))
          $display("FAIL random unit %0d spike %0d: got tag=%h ct=%0d expected tag=%h ct=1",
                   units, i, obs_q[i].tag, obs_q[i].ct, exp_q[i]);
        else passed++;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    time_unit_pulse = 1'b0;
    prog_bus.v = 1'b0;
    prog_bus.gen_idx = '0;
    prog_bus.period = '0;
    prog_bus.ticks = '0;
    prog_bus.tag = '0;
    out_bus.r = 1'b1;
    model_clear();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_idle_pulses();
    test_gen5();
    test_same_cycle();
    test_stall();
    test_overrun();
    test_reset_mid_emit();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
